// File: rtl/nextasic_pkg.sv
// Shared types and constants for the NeXT ASIC serial frame receiver.
package nextasic_pkg;

  // Receiver FSM states; the top module mirrors these as plain 3-bit constants.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    PAR   = 3'd2,
    DONE  = 3'd3,
    GAP   = 3'd4
  } rx_state_t;

  localparam int   NEXTASIC_FRAME_W   = 40;
  localparam logic NEXTASIC_START_BIT = 1'b1;

endpackage

// File: rtl/nextasic_sync_fifo.sv
// Show-ahead synchronous FIFO. The head word is visible on rdata whenever the
// FIFO is non-empty; when empty, rdata holds the last popped word (0 after reset).
// Pointers carry one extra MSB so full and empty are distinguishable.
module nextasic_sync_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] hold_reg;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign level   = wr_ptr_reg - rd_ptr_reg;
  assign pop_ok  = pop && !empty;
  // A pop on the same edge frees the slot a full FIFO would otherwise refuse.
  assign push_ok = push && (!full || pop_ok);

  // Storage entries are reset so the head output can never show X.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;

      // Capture the write word when this slot is addressed by the write pointer.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg <= '0;
        end else if (push_ok && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
          entry_reg <= wdata;
        end
      end

      assign mem_q[gi] = entry_reg;
    end
  endgenerate

  // Pointer advance and retention of the most recently popped word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      hold_reg   <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        hold_reg   <= mem_q[rd_ptr_reg[AW-1:0]];
      end
    end
  end

  assign rdata = empty ? hold_reg : mem_q[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/nextasic_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits MSB-first, optional even
// parity bit, then queued into a show-ahead FIFO drained by a valid/ready port.
// Optional feature macro: NEXTASIC_RX_PARITY_EN (adds the parity bit per frame).
module nextasic_frame_rx
  import nextasic_pkg::*;
#(
  parameter int DATA_W     = NEXTASIC_FRAME_W,
  parameter int DEPTH      = 2,
  parameter int GAP_CYCLES = 1,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              si,
  output logic [DATA_W-1:0] m_data,
  output logic              m_perr,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              overrun,
  input  logic              clr_overrun,
  output logic [LW-1:0]     level,
  output logic              busy
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_SHIFT = SHIFT;
  localparam logic [2:0] S_PAR   = PAR;
  localparam logic [2:0] S_DONE  = DONE;
  localparam logic [2:0] S_GAP   = GAP;
  localparam int         CNT_W   = $clog2(DATA_W + 1);

`ifdef NEXTASIC_RX_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
  localparam int FW        = DATA_W + 1;
`else
  localparam bit PARITY_ON = 1'b0;
  localparam int FW        = DATA_W;
`endif

  logic [2:0]        state_reg;
  logic [DATA_W-1:0] sr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [3:0]        gap_cnt_reg;
  logic              overrun_reg;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FW-1:0]     push_word;
  logic [FW-1:0]     head_word;

  // Frame FSM: start detect, shifting, optional parity, push cycle, guard gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      sr_reg      <= '0;
      cnt_reg     <= '0;
      gap_cnt_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (si == NEXTASIC_START_BIT) begin
            state_reg <= S_SHIFT;
            cnt_reg   <= '0;
          end
        end
        S_SHIFT: begin
          sr_reg  <= {sr_reg[DATA_W-2:0], si};
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(DATA_W - 1)) begin
            state_reg <= PARITY_ON ? S_PAR : S_DONE;
          end
        end
        S_PAR: state_reg <= S_DONE;
        S_DONE: begin
          gap_cnt_reg <= '0;
          state_reg   <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
        S_GAP: begin
          if (gap_cnt_reg == 4'(GAP_CYCLES - 1)) begin
            state_reg <= S_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 4'd1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef NEXTASIC_RX_PARITY_EN
  logic par_reg;

  // Latch the trailing parity bit while in PAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_reg <= 1'b0;
    end else if (state_reg == S_PAR) begin
      par_reg <= si;
    end
  end

  // Even parity over data plus parity bit: a set result flags an error.
  assign push_word = {^{sr_reg, par_reg}, sr_reg};
  assign m_perr    = head_word[FW-1];
`else
  assign push_word = sr_reg;
  assign m_perr    = 1'b0;
`endif

  assign push    = (state_reg == S_DONE);
  assign pop     = m_ready && m_valid;
  assign m_valid = !fifo_empty;
  assign m_data  = head_word[DATA_W-1:0];
  assign busy    = (state_reg != S_IDLE);
  assign overrun = overrun_reg;

  // Sticky overrun: set on a refused push, cleared by pulse; set has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_reg <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overrun_reg <= 1'b1;
    end else if (clr_overrun) begin
      overrun_reg <= 1'b0;
    end
  end

  nextasic_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (push_word),
    .rdata (head_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

endmodule
